riscv_i32_fetch_data_buffer: RTL and testbench

Registered, parametrised successor to the combinational fetch-data stage. It captures each instruction-fetch response with its request context (PC, mode, branch prediction) into a DEPTH-entry FIFO and presents the head entry to decode with a valid/ready handshake. Debug-fetch substitution and debug-instruction injection are applied at push time. The buffer sits between the ifetch interface and the decode/execute stage. It decouples fetch from decode stalls and supplies a registered output.

---
 rtl/riscv_i32_fetch_data_buffer.sv | 111 +++++++++++
 tb/tb_riscv_i32_fetch_data_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/riscv_i32_fetch_data_buffer.sv
// riscv_i32_fetch_data_buffer: DEPTH-entry FIFO between ifetch responses and decode.
// Debug-fetch substitution and debug-instruction injection are resolved at push time.
module riscv_i32_fetch_data_buffer #(
  parameter int          DEPTH           = 2,
  parameter int          DEBUG_ADDR_BITS = 8,
  parameter logic [31:0] DEBUG_EBREAK    = 32'h0010_0073
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ifetch_req__flush_pipeline,
  input  logic [2:0]                     ifetch_req__req_type,
  input  logic [31:0]                    ifetch_req__address,
  input  logic [2:0]                     ifetch_req__mode,
  input  logic                           ifetch_resp__valid,
  input  logic [31:0]                    ifetch_resp__data,
  input  logic                           pipeline_fetch_req__debug_fetch,
  input  logic                           pipeline_fetch_req__predicted_branch,
  input  logic [31:0]                    pipeline_fetch_req__pc_if_mispredicted,
  input  logic [31:0]                    pipeline_state__instruction_data,
  input  logic                           pipeline_state__instruction_debug__valid,
  input  logic [1:0]                     pipeline_state__instruction_debug__debug_op,
  input  logic [15:0]                    pipeline_state__instruction_debug__data,
  input  logic                           decode_ready,
  output logic                           pipeline_fetch_data__valid,
  output logic [2:0]                     pipeline_fetch_data__mode,
  output logic [31:0]                    pipeline_fetch_data__pc,
  output logic [2:0]                     pipeline_fetch_data__instruction__mode,
  output logic [31:0]                    pipeline_fetch_data__instruction__data,
  output logic                           pipeline_fetch_data__instruction__debug__valid,
  output logic [1:0]                     pipeline_fetch_data__instruction__debug__debug_op,
  output logic [15:0]                    pipeline_fetch_data__instruction__debug__data,
  output logic                           pipeline_fetch_data__dec_predicted_branch,
  output logic [31:0]                    pipeline_fetch_data__dec_pc_if_mispredicted,
  output logic                           buffer_full,
  output logic [$clog2(DEPTH+1)-1:0]     buffer_count,
  output logic                           overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] pc;
    logic [31:0] data;
    logic        dbg_valid;
    logic [1:0]  dbg_op;
    logic [15:0] dbg_data;
    logic        pred;
    logic [31:0] pc_mis;
  } entry_t;
  entry_t        r_mem [DEPTH];
  entry_t        w_entry, w_out;
  logic [PW-1:0] r_rd, r_wr, w_wr_idx;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_push_req, w_pop, w_full, w_do_push, w_wr_en, w_dbg_hit;
  assign w_push_req = (ifetch_resp__valid && ifetch_req__req_type != 3'd0) ||
                      pipeline_fetch_req__debug_fetch || pipeline_state__instruction_debug__valid;
  assign w_full     = r_count == CW'(DEPTH);
  assign w_pop      = pipeline_fetch_data__valid && decode_ready;
  assign w_do_push  = w_push_req && (!w_full || w_pop);
  assign w_wr_en    = ifetch_req__flush_pipeline ? w_push_req : w_do_push;
  assign w_wr_idx   = ifetch_req__flush_pipeline ? '0 : r_wr;
  assign w_dbg_hit  = ifetch_req__address[DEBUG_ADDR_BITS-1:0] == '0;
  always_comb begin
    w_entry           = '0;
    w_entry.mode      = ifetch_req__mode;
    w_entry.pc        = ifetch_req__address;
    w_entry.pred      = pipeline_fetch_req__predicted_branch;
    w_entry.pc_mis    = pipeline_fetch_req__pc_if_mispredicted;
    w_entry.data      = pipeline_state__instruction_debug__valid ? pipeline_state__instruction_data :
                        !pipeline_fetch_req__debug_fetch          ? ifetch_resp__data :
                        w_dbg_hit                                 ? pipeline_state__instruction_data :
                                                                    DEBUG_EBREAK;
    w_entry.dbg_valid = pipeline_state__instruction_debug__valid;
    w_entry.dbg_op    = pipeline_state__instruction_debug__valid ? pipeline_state__instruction_debug__debug_op : 2'd0;
    w_entry.dbg_data  = pipeline_state__instruction_debug__valid ? pipeline_state__instruction_debug__data : 16'd0;
  end
  always_ff @(posedge clk) if (w_wr_en) r_mem[w_wr_idx] <= w_entry;
  // flush wins over pop; a same-cycle push lands in slot 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (ifetch_req__flush_pipeline) begin
      r_rd    <= '0;
      r_wr    <= PW'(w_push_req);
      r_count <= CW'(w_push_req);
    end else begin
      r_rd       <= r_rd + PW'(w_pop);
      r_wr       <= r_wr + PW'(w_do_push);
      r_count    <= r_count + CW'(w_do_push) - CW'(w_pop);
      r_overflow <= r_overflow || (w_push_req && w_full && !w_pop);
    end
  end
  assign pipeline_fetch_data__valid = r_count != '0;
  assign w_out = pipeline_fetch_data__valid ? r_mem[r_rd] : '0;
  assign pipeline_fetch_data__mode                         = w_out.mode;
  assign pipeline_fetch_data__pc                           = w_out.pc;
  assign pipeline_fetch_data__instruction__mode            = w_out.mode;
  assign pipeline_fetch_data__instruction__data            = w_out.data;
  assign pipeline_fetch_data__instruction__debug__valid    = w_out.dbg_valid;
  assign pipeline_fetch_data__instruction__debug__debug_op = w_out.dbg_op;
  assign pipeline_fetch_data__instruction__debug__data     = w_out.dbg_data;
  assign pipeline_fetch_data__dec_predicted_branch         = w_out.pred;
  assign pipeline_fetch_data__dec_pc_if_mispredicted       = w_out.pc_mis;
  assign buffer_full  = w_full;
  assign buffer_count = r_count;
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_riscv_i32_fetch_data_buffer.sv
// tb_riscv_i32_fetch_data_buffer: table-driven directed vectors plus hand sequences
// for async reset and push latency.
module tb_riscv_i32_fetch_data_buffer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        fl, rv, df, pred, idv, rdy;
  logic [2:0]  rt, mode;
  logic [31:0] a, d, pcmis, sd;
  logic [1:0]  op;
  logic [15:0] idd;
  logic        o_valid, o_dv, o_pred, o_full, o_ovf;
  logic [2:0]  o_mode, o_imode;
  logic [31:0] o_pc, o_data, o_pcmis;
  logic [1:0]  o_op, o_cnt;
  logic [15:0] o_dd;
  int          n_pass = 0, n_total = 0;

  riscv_i32_fetch_data_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .ifetch_req__flush_pipeline(fl), .ifetch_req__req_type(rt), .ifetch_req__address(a),
    .ifetch_req__mode(mode), .ifetch_resp__valid(rv), .ifetch_resp__data(d),
    .pipeline_fetch_req__debug_fetch(df), .pipeline_fetch_req__predicted_branch(pred),
    .pipeline_fetch_req__pc_if_mispredicted(pcmis), .pipeline_state__instruction_data(sd),
    .pipeline_state__instruction_debug__valid(idv), .pipeline_state__instruction_debug__debug_op(op),
    .pipeline_state__instruction_debug__data(idd), .decode_ready(rdy),
    .pipeline_fetch_data__valid(o_valid), .pipeline_fetch_data__mode(o_mode),
    .pipeline_fetch_data__pc(o_pc), .pipeline_fetch_data__instruction__mode(o_imode),
    .pipeline_fetch_data__instruction__data(o_data),
    .pipeline_fetch_data__instruction__debug__valid(o_dv),
    .pipeline_fetch_data__instruction__debug__debug_op(o_op),
    .pipeline_fetch_data__instruction__debug__data(o_dd),
    .pipeline_fetch_data__dec_predicted_branch(o_pred),
    .pipeline_fetch_data__dec_pc_if_mispredicted(o_pcmis),
    .buffer_full(o_full), .buffer_count(o_cnt), .overflow(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl; logic [2:0] rt; logic [31:0] a; logic rv; logic [31:0] d;
    logic df; logic [31:0] sd; logic idv; logic rdy;
    logic ev; logic [31:0] epc; logic [31:0] edata; logic [1:0] ecnt; logic eovf; logic edv;
  } vec_t;
  vec_t vecs [19];

  function automatic vec_t v(input logic fl_i, input logic [2:0] rt_i, input logic [31:0] a_i,
                             input logic rv_i, input logic [31:0] d_i, input logic df_i,
                             input logic [31:0] sd_i, input logic idv_i, input logic rdy_i,
                             input logic ev_i, input logic [31:0] epc_i, input logic [31:0] ed_i,
                             input logic [1:0] ecnt_i, input logic eovf_i, input logic edv_i);
    vec_t r;
    r.fl = fl_i; r.rt = rt_i; r.a = a_i; r.rv = rv_i; r.d = d_i; r.df = df_i; r.sd = sd_i;
    r.idv = idv_i; r.rdy = rdy_i; r.ev = ev_i; r.epc = epc_i; r.edata = ed_i;
    r.ecnt = ecnt_i; r.eovf = eovf_i; r.edv = edv_i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // prediction flag and recovery PC are derived from the address so every entry is distinct
  task automatic drive(input vec_t x);
    fl = x.fl; rt = x.rt; a = x.a; rv = x.rv; d = x.d; df = x.df; sd = x.sd;
    idv = x.idv; rdy = x.rdy; mode = 3'd3; pred = x.a[4]; pcmis = x.a + 32'd8;
    op = 2'd2; idd = 16'h1234;
  endtask

  task automatic check_head(input string tag, input vec_t x);
    check({tag, " valid"}, 32'(o_valid), 32'(x.ev));
    check({tag, " pc"}, o_pc, x.ev ? x.epc : 32'd0);
    check({tag, " data"}, o_data, x.ev ? x.edata : 32'd0);
    check({tag, " count"}, 32'(o_cnt), 32'(x.ecnt));
    check({tag, " full"}, 32'(o_full), 32'(x.ecnt == 2'd2));
    check({tag, " overflow"}, 32'(o_ovf), 32'(x.eovf));
    check({tag, " mode"}, {26'd0, o_mode, o_imode}, x.ev ? 32'h1b : 32'd0);
    check({tag, " pred"}, 32'(o_pred), x.ev ? 32'(x.epc[4]) : 32'd0);
    check({tag, " pcmis"}, o_pcmis, x.ev ? x.epc + 32'd8 : 32'd0);
    check({tag, " dbg"}, {13'd0, o_dv, o_op, o_dd}, x.edv ? {13'd0, 1'b1, 2'd2, 16'h1234} : 32'd0);
  endtask

  vec_t idle;
  initial begin
    idle = v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    drive(idle);
    vecs[0]  = v(0,1,32'h100,1,32'h13,0,0,0,1,          1,32'h100,32'h13,1,0,0);
    vecs[1]  = v(0,0,32'h0,0,0,0,0,0,1,                 0,0,0,0,0,0);
    vecs[2]  = v(0,1,32'h110,1,32'hA1,0,0,0,0,          1,32'h110,32'hA1,1,0,0);
    vecs[3]  = v(0,1,32'h120,1,32'hA2,0,0,0,0,          1,32'h110,32'hA1,2,0,0);
    vecs[4]  = v(0,1,32'h130,1,32'hA3,0,0,0,0,          1,32'h110,32'hA1,2,1,0);
    vecs[5]  = v(0,1,32'h140,1,32'hA4,0,0,0,1,          1,32'h120,32'hA2,2,1,0);
    vecs[6]  = v(0,0,32'h0,0,0,0,0,0,1,                 1,32'h140,32'hA4,1,1,0);
    vecs[7]  = v(0,0,32'h0,0,0,0,0,0,1,                 0,0,0,0,1,0);
    vecs[8]  = v(0,0,32'h800,0,32'h55,1,32'hDEADBEEF,0,0, 1,32'h800,32'hDEADBEEF,1,1,0);
    vecs[9]  = v(0,0,32'h804,0,32'h55,1,32'hDEADBEEF,0,1, 1,32'h804,32'h00100073,1,1,0);
    vecs[10] = v(0,0,32'h900,0,32'h66,0,32'hCAFEF00D,1,1, 1,32'h900,32'hCAFEF00D,1,1,1);
    vecs[11] = v(0,0,32'h0,0,0,0,0,0,1,                 0,0,0,0,1,0);
    vecs[12] = v(0,0,32'h950,1,32'h77,0,0,0,1,          0,0,0,0,1,0);
    vecs[13] = v(0,1,32'h180,1,32'hD1,0,0,0,0,          1,32'h180,32'hD1,1,1,0);
    vecs[14] = v(0,1,32'h190,1,32'hD2,0,0,0,0,          1,32'h180,32'hD1,2,1,0);
    vecs[15] = v(1,1,32'h200,1,32'hD3,0,0,0,1,          1,32'h200,32'hD3,1,1,0);
    vecs[16] = v(0,0,32'h0,0,0,0,0,0,0,                 1,32'h200,32'hD3,1,1,0);
    vecs[17] = v(1,0,32'h0,0,0,0,0,0,0,                 0,0,0,0,1,0);
    vecs[18] = v(1,1,32'h210,1,32'hD5,0,0,0,0,          1,32'h210,32'hD5,1,1,0);

    repeat (2) @(negedge clk);
    check_head("reset", idle);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      check_head($sformatf("vec%0d", i), vecs[i]);
    end

    @(negedge clk);
    drive(v(0,1,32'h220,1,32'hD6,0,0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    check("pre-reset count", 32'(o_cnt), 32'd2);
    @(negedge clk);
    drive(idle);
    #2 reset_n = 1'b0;
    #1;
    check("async reset valid", 32'(o_valid), 32'd0);
    check("async reset count", 32'(o_cnt), 32'd0);
    check("async reset overflow", 32'(o_ovf), 32'd0);
    check("async reset pc", o_pc, 32'd0);
    check("async reset data", o_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(v(0,1,32'h300,1,32'h77,0,0,0,0, 0,0,0,0,0,0));
    #1;
    check("no comb path valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    check("post-reset valid", 32'(o_valid), 32'd1);
    check("post-reset pc", o_pc, 32'h300);
    check("post-reset overflow", 32'(o_ovf), 32'd0);
    check("post-reset count", 32'(o_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
